// File: rtl/spi_xfer_sequencer_if.sv
// Register-bus interface between the transfer sequencer and an SPI master
// peripheral.
//   psel    : access select, high for exactly one cycle per access
//   penable : active-low strobe, low while psel is high
//   we / re : write / read qualifier, exactly one high during an access
//   addrd   : register address
//   datao   : write data (sequencer to peripheral)
//   datai   : read data (peripheral to sequencer), valid in the access cycle
interface spi_xfer_sequencer_if;
  logic       psel;
  logic       penable;
  logic       we;
  logic       re;
  logic [7:0] addrd;
  logic [7:0] datao;
  logic [7:0] datai;

  modport master (
    output psel, penable, we, re, addrd, datao,
    input  datai
  );

  modport slave (
    input  psel, penable, we, re, addrd, datao,
    output datai
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Multi-byte SPI transfer sequencer. Drives an SPI master peripheral through
// its register bus: configures SPCR once, then per byte writes SPDR, polls
// SPSR until the transfer-complete bit is set, reads SPDR into a receive FIFO
// and clears SPSR. A per-byte poll budget aborts the transfer with a sticky
// error flag.
// Ports:
//   CLK, RESET        : clock, asynchronous active-high reset
//   start             : one-cycle pulse, accepted only while idle
//   xfer_len          : byte count sampled on start (0 means 256)
//   spcr_cfg          : SPI control value sampled on start (bit 6 forced on)
//   tx_data/valid/ready : transmit byte stream into the sequencer
//   rx_data/valid/ready : receive byte stream from the FIFO head
//   busy, done, err   : status (done is a pulse, err is sticky)
//   bus               : register-bus master port
module spi_xfer_sequencer #(
  parameter logic [7:0] SPCR_ADDR = 8'h02,
  parameter logic [7:0] SPSR_ADDR = 8'h03,
  parameter logic [7:0] SPDR_ADDR = 8'h04,
  parameter int         RX_DEPTH  = 4,
  parameter int         TIMEOUT   = 4095
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        start,
  input  logic [7:0]                  xfer_len,
  input  logic [7:0]                  spcr_cfg,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  spi_xfer_sequencer_if.master        bus
);

  localparam int          AW        = $clog2(RX_DEPTH);
  localparam logic [11:0] TIMEOUT_C = 12'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WRDR  = 3'd3,
    ST_POLL  = 3'd4,
    ST_RDDR  = 3'd5,
    ST_CLR   = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  state_t      state_r, state_nx_s;
  logic [8:0]  cnt_r;
  logic [11:0] poll_cnt_r;
  logic        err_r;

  logic        psel_r, penable_r, we_r, re_r;
  logic [7:0]  addr_r, data_r;
  logic        psel_nx_s, we_nx_s, re_nx_s;
  logic [7:0]  addr_nx_s, data_nx_s;

  logic [7:0]  mem_r [RX_DEPTH];
  logic [AW:0] wptr_r, rptr_r;
  logic        full_s, empty_s, push_s, pop_s;

  logic        tx_fire_s, poll_hit_s, poll_last_s, cnt_last_s;

  // FIFO status: the extra pointer bit separates full from empty
  assign empty_s = (wptr_r == rptr_r);
  assign full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign push_s  = (state_r == ST_RDDR);
  assign pop_s   = ~empty_s & rx_ready;

  // FETCH only offers a slot when the byte's eventual push cannot overflow;
  // between FETCH and RDDR only pops can change the FIFO level
  assign tx_ready    = (state_r == ST_FETCH) & ~full_s;
  assign tx_fire_s   = tx_ready & tx_valid;
  assign poll_hit_s  = bus.datai[0];
  assign poll_last_s = ((poll_cnt_r + 12'd1) == TIMEOUT_C);
  assign cnt_last_s  = (cnt_r == 9'd1);

  assign busy     = (state_r != ST_IDLE);
  assign done     = (state_r == ST_DONE);
  assign err      = err_r;
  assign rx_valid = ~empty_s;
  assign rx_data  = mem_r[rptr_r[AW-1:0]];

  assign bus.psel    = psel_r;
  assign bus.penable = penable_r;
  assign bus.we      = we_r;
  assign bus.re      = re_r;
  assign bus.addrd   = addr_r;
  assign bus.datao   = data_r;

  // Next-state decode, then the bus access belonging to the next state
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_nx_s = ST_CFG; else state_nx_s = ST_IDLE;
      ST_CFG:   state_nx_s = ST_FETCH;
      ST_FETCH: if (tx_fire_s) state_nx_s = ST_WRDR; else state_nx_s = ST_FETCH;
      ST_WRDR:  state_nx_s = ST_POLL;
      ST_POLL: begin
        if (poll_hit_s)       state_nx_s = ST_RDDR;
        else if (poll_last_s) state_nx_s = ST_DONE;
        else                  state_nx_s = ST_POLL;
      end
      ST_RDDR:  state_nx_s = ST_CLR;
      ST_CLR:   if (cnt_last_s) state_nx_s = ST_DONE; else state_nx_s = ST_FETCH;
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase

    psel_nx_s = 1'b0;
    we_nx_s   = 1'b0;
    re_nx_s   = 1'b0;
    addr_nx_s = 8'h00;
    data_nx_s = 8'h00;
    // CFG is only entered from IDLE on start and WRDR only from a FETCH
    // handshake, so the raw inputs are the values to be latched
    case (state_nx_s)
      ST_CFG:  begin psel_nx_s = 1'b1; we_nx_s = 1'b1; addr_nx_s = SPCR_ADDR; data_nx_s = spcr_cfg | 8'h40; end
      ST_WRDR: begin psel_nx_s = 1'b1; we_nx_s = 1'b1; addr_nx_s = SPDR_ADDR; data_nx_s = tx_data; end
      ST_POLL: begin psel_nx_s = 1'b1; re_nx_s = 1'b1; addr_nx_s = SPSR_ADDR; end
      ST_RDDR: begin psel_nx_s = 1'b1; re_nx_s = 1'b1; addr_nx_s = SPDR_ADDR; end
      ST_CLR:  begin psel_nx_s = 1'b1; we_nx_s = 1'b1; addr_nx_s = SPSR_ADDR; data_nx_s = 8'h01; end
      default: begin psel_nx_s = 1'b0; end
    endcase
  end

  // State register and registered bus outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      psel_r    <= 1'b0;
      penable_r <= 1'b1;
      we_r      <= 1'b0;
      re_r      <= 1'b0;
      addr_r    <= 8'h00;
      data_r    <= 8'h00;
    end else begin
      state_r   <= state_nx_s;
      psel_r    <= psel_nx_s;
      penable_r <= ~psel_nx_s;
      we_r      <= we_nx_s;
      re_r      <= re_nx_s;
      addr_r    <= addr_nx_s;
      data_r    <= data_nx_s;
    end
  end

  // Byte counter, per-byte poll counter and sticky timeout flag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_r      <= 9'd0;
      poll_cnt_r <= 12'd0;
      err_r      <= 1'b0;
    end else begin
      if (state_r == ST_IDLE && start) begin
        cnt_r <= (xfer_len == 8'd0) ? 9'd256 : {1'b0, xfer_len};
        err_r <= 1'b0;
      end else if (state_r == ST_CLR) begin
        cnt_r <= cnt_r - 9'd1;
      end
      if (state_r == ST_WRDR) begin
        poll_cnt_r <= 12'd0;
      end else if (state_r == ST_POLL && !poll_hit_s) begin
        poll_cnt_r <= poll_cnt_r + 12'd1;
        if (poll_last_s) err_r <= 1'b1;
      end
    end
  end

  // FIFO pointers; push and pop are independent and may coincide
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_s) wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_s)  rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // FIFO storage, written with the SPDR read data
  always_ff @(posedge CLK) begin
    if (push_s) mem_r[wptr_r[AW-1:0]] <= bus.datai;
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer. A loopback SPI slave model
// answers the register bus (configurable completion delay, data key and a
// hang switch). Expected bus access sequences, receive bytes, poll misses and
// status are built per transfer from the transfer-level rules.
module tb_spi_xfer_sequencer;
  localparam logic [7:0] SPCR    = 8'h02;
  localparam logic [7:0] SPSR    = 8'h03;
  localparam logic [7:0] SPDR    = 8'h04;
  localparam int         TIMEOUT = 4095;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start;
  logic [7:0] xfer_len, spcr_cfg, tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, busy, done, err;

  spi_xfer_sequencer_if bus_if ();

  spi_xfer_sequencer dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .xfer_len (xfer_len),
    .spcr_cfg (spcr_cfg),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus_if)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- SPI slave model (loopback with key) ----------------
  logic       hang;
  logic [7:0] slave_key, loop_byte, slave_datai;
  int         slave_delay;
  int         dly = 0;

  always @(posedge CLK) begin
    if (bus_if.psel && bus_if.we && bus_if.addrd == SPDR) begin
      loop_byte <= bus_if.datao ^ slave_key;
      dly       <= slave_delay;
    end else if (bus_if.psel && bus_if.re && bus_if.addrd == SPSR && dly != 0) begin
      dly <= dly - 1;
    end
  end

  always_comb begin
    slave_datai = 8'h00;
    if (bus_if.psel && bus_if.re && bus_if.addrd == SPSR)
      slave_datai = {7'd0, (dly == 0 && !hang)};
    else if (bus_if.psel && bus_if.re && bus_if.addrd == SPDR)
      slave_datai = loop_byte;
  end
  assign bus_if.datai = slave_datai;

  // ---------------- shared stimulus / observation state ----------------
  logic [17:0] act_bus[$];
  logic [17:0] exp_bus[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_exp[$];
  int rx_mode = 0;
  int poll_miss = 0, done_cnt = 0, tx_taken = 0, rx_got = 0;
  int done_base, act_base, miss_base, taken_base, rx_base;
  int exp_miss, exp_taken, exp_rx_n;
  bit exp_err;

  // Monitor and stream driver: observes at negedge, then drives inputs
  initial begin
    bit         tx_take;
    logic [7:0] exp_b;
    tx_take  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    forever begin
      @(negedge CLK);
      if (tx_take && !RESET) begin
        void'(tx_q.pop_front());
        tx_taken++;
      end
      tx_take = 1'b0;
      if (!RESET) begin
        if (bus_if.psel) begin
          check_val("acc_strobe", {30'd0, bus_if.penable, bus_if.we ^ bus_if.re}, 32'd1);
          if (bus_if.re && bus_if.addrd == SPSR) begin
            if (bus_if.datai[0]) act_bus.push_back({2'b01, SPSR, 8'h01});
            else poll_miss++;
          end else begin
            act_bus.push_back({bus_if.we, bus_if.re, bus_if.addrd,
                               bus_if.we ? bus_if.datao : bus_if.datai});
          end
        end else begin
          check_val("bus_idle", {13'd0, bus_if.penable, bus_if.we, bus_if.re,
                                 bus_if.addrd, bus_if.datao}, 32'h0004_0000);
        end
        if (done) done_cnt++;
      end
      rx_ready = (rx_mode == 0) ? 1'b1 : (rx_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rx_valid && rx_ready && !RESET) begin
        if (rx_exp.size() == 0) begin
          check_val("rx_unexpected", 32'd1, 32'd0);
        end else begin
          exp_b = rx_exp.pop_front();
          check_val("rx_data", rx_data, exp_b);
        end
        rx_got++;
      end
      tx_valid = (tx_q.size() != 0);
      tx_data  = tx_valid ? tx_q[0] : 8'h00;
      if (tx_valid && tx_ready) tx_take = 1'b1;
    end
  end

  // Builds the transfer-level expectation and pulses start.
  // seed_byte >= 0 gives bytes seed, seed+0x11, ...; hang_first stalls byte 0.
  task automatic start_xfer(input logic [7:0] len, input logic [7:0] cfg, input int delay,
                            input logic [7:0] key, input bit hang_first, input int seed_byte);
    int n;
    logic [7:0] b;
    @(posedge CLK);
    n = (len == 8'd0) ? 256 : int'(len);
    exp_bus.delete();
    rx_exp.delete();
    tx_q.delete();
    act_base   = act_bus.size();
    miss_base  = poll_miss;
    taken_base = tx_taken;
    rx_base    = rx_got;
    done_base  = done_cnt;
    slave_delay = delay;
    slave_key   = key;
    hang        = hang_first;
    exp_miss = 0;
    exp_rx_n = 0;
    exp_err  = hang_first;
    exp_taken = hang_first ? 1 : n;
    exp_bus.push_back({2'b10, SPCR, cfg | 8'h40});
    for (int i = 0; i < n; i++) begin
      b = (seed_byte >= 0) ? 8'(seed_byte + 17 * i) : 8'($urandom);
      tx_q.push_back(b);
      if (hang_first) begin
        if (i == 0) begin
          exp_bus.push_back({2'b10, SPDR, b});
          exp_miss = TIMEOUT;
        end
      end else begin
        exp_bus.push_back({2'b10, SPDR, b});
        exp_bus.push_back({2'b01, SPSR, 8'h01});
        exp_bus.push_back({2'b01, SPDR, b ^ key});
        exp_bus.push_back({2'b10, SPSR, 8'h01});
        rx_exp.push_back(b ^ key);
        exp_rx_n++;
        exp_miss += delay;
      end
    end
    #1;
    xfer_len = len;
    spcr_cfg = cfg;
    start    = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  // Waits for completion (bounded) and compares everything observed
  task automatic finish_xfer(input string name);
    int cyc;
    int nact;
    cyc = 0;
    while (done_cnt == done_base && cyc < 20000) begin
      @(posedge CLK);
      cyc++;
    end
    repeat (4) @(posedge CLK);
    #1;
    check_val({name, ".done_pulses"}, done_cnt - done_base, 32'd1);
    check_val({name, ".busy"}, busy, 32'd0);
    check_val({name, ".err"}, err, exp_err);
    rx_mode = 0;
    cyc = 0;
    while (rx_exp.size() != 0 && cyc < 64) begin
      @(posedge CLK);
      cyc++;
    end
    repeat (2) @(posedge CLK);
    #1;
    check_val({name, ".rx_count"}, rx_got - rx_base, exp_rx_n);
    check_val({name, ".rx_drained"}, rx_valid, 32'd0);
    check_val({name, ".poll_misses"}, poll_miss - miss_base, exp_miss);
    check_val({name, ".tx_taken"}, tx_taken - taken_base, exp_taken);
    nact = act_bus.size() - act_base;
    check_val({name, ".bus_len"}, nact, exp_bus.size());
    for (int i = 0; i < exp_bus.size() && i < nact; i++) begin
      check_val($sformatf("%s.bus[%0d]", name, i), act_bus[act_base + i], exp_bus[i]);
      if (act_bus[act_base + i] !== exp_bus[i]) break;
    end
  endtask

  initial begin
    int  cyc;
    int  dbase;
    bit  seen;
    RESET = 1'b1;
    start = 1'b0;
    xfer_len = 8'h00;
    spcr_cfg = 8'h00;
    hang = 1'b0;
    slave_delay = 0;
    slave_key = 8'h00;

    // reset state
    repeat (3) @(negedge CLK);
    check_val("reset0.ctrl", {tx_ready, rx_valid, busy, done, err, bus_if.psel,
                              bus_if.penable, bus_if.we, bus_if.re}, 32'h004);
    check_val("reset0.data", {bus_if.addrd, bus_if.datao}, 32'd0);
    RESET = 1'b0;
    repeat (2) @(posedge CLK);

    // single byte loopback, cfg 0x10 -> SPCR 0x50, byte A5
    start_xfer(8'd1, 8'h10, 2, 8'h00, 1'b0, 8'hA5);
    finish_xfer("single");

    // three bytes 11/22/33 in order
    start_xfer(8'd3, 8'h01, 1, 8'h00, 1'b0, 8'h11);
    finish_xfer("three");

    // receive back-pressure: FIFO fills after 4 bytes and FETCH stalls
    rx_mode = 2;
    start_xfer(8'd6, 8'h22, 1, 8'h5A, 1'b0, -1);
    repeat (150) @(posedge CLK);
    #1;
    check_val("stall.tx_taken", tx_taken - taken_base, 32'd4);
    check_val("stall.tx_ready", tx_ready, 32'd0);
    check_val("stall.rx_valid", rx_valid, 32'd1);
    check_val("stall.busy", busy, 32'd1);
    rx_mode = 0;
    finish_xfer("stall");

    // start pulsed while busy is ignored
    start_xfer(8'd3, 8'h81, 0, 8'h0F, 1'b0, -1);
    repeat (5) @(posedge CLK);
    #1 xfer_len = 8'd9;
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    finish_xfer("restart_ignored");

    // poll timeout on first byte
    start_xfer(8'd2, 8'h07, 0, 8'h00, 1'b1, -1);
    finish_xfer("timeout");
    repeat (5) @(posedge CLK);
    #1 check_val("timeout.err_sticky", err, 32'd1);

    // randomized transfers (the first one also clears err)
    for (int t = 0; t < 6; t++) begin
      rx_mode = 1;
      start_xfer(8'($urandom_range(1, 12)), 8'($urandom), $urandom_range(0, 3),
                 8'($urandom), 1'b0, -1);
      finish_xfer($sformatf("rand%0d", t));
    end

    // length 0 means 256 bytes
    start_xfer(8'd0, 8'h33, 0, 8'hC3, 1'b0, -1);
    finish_xfer("len256");

    // reset while polling with two bytes held in the FIFO
    rx_mode = 2;
    start_xfer(8'd5, 8'h3C, 0, 8'h00, 1'b0, -1);
    cyc = 0;
    while ((act_bus.size() - act_base) < 9 && cyc < 500) begin
      @(posedge CLK);
      cyc++;
    end
    hang = 1'b1;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (bus_if.psel && bus_if.re && bus_if.addrd == SPSR) seen = 1'b1;
    end
    check_val("abort.in_poll", seen, 32'd1);
    check_val("abort.fifo_loaded", rx_valid, 32'd1);
    dbase = done_cnt;
    #2 RESET = 1'b1;
    #1;
    check_val("abort.ctrl", {tx_ready, rx_valid, busy, done, err, bus_if.psel,
                             bus_if.penable, bus_if.we, bus_if.re}, 32'h004);
    check_val("abort.data", {bus_if.addrd, bus_if.datao}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    hang = 1'b0;
    rx_mode = 0;
    repeat (4) @(posedge CLK);
    #1;
    check_val("abort.no_done", done_cnt - dbase, 32'd0);
    check_val("abort.idle", {busy, rx_valid}, 32'd0);

    // normal operation after the abort
    start_xfer(8'd2, 8'h44, 1, 8'h99, 1'b0, -1);
    finish_xfer("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
